// File: rtl/ines_rom_writer.sv
// iNES image loader: parses the 16-byte header, skips the optional trainer and
// streams PRG/CHR bytes from a small input FIFO into a valid/ready memory port.
module ines_rom_writer #(
  parameter int unsigned       ADDR_W     = 22,
  parameter logic [ADDR_W-1:0] CHR_BASE   = 22'h200000,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              loading,
  output logic              done,
  output logic [1:0]        error,
  output logic [7:0]        prg_banks,
  output logic [7:0]        chr_banks,
  output logic [7:0]        mapper,
  output logic              mirroring,
  output logic              has_battery
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0] SPACE    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CHR_ROOM = SPACE - {1'b0, CHR_BASE};

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_TRAIN, S_PRG, S_CHR, S_DONE, S_ERR
  } state_t;

  typedef enum logic [1:0] {
    E_NONE, E_MAGIC, E_OVF, E_SIZE
  } err_t;

  state_t            state_q, state_d;
  err_t              err_q, err_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    fill_q, fill_d;
  logic [7:0]        fifo_q [FIFO_DEPTH];
  logic [7:0]        prg_banks_q, prg_banks_d;
  logic [7:0]        chr_banks_q, chr_banks_d;
  logic [7:0]        mapper_q, mapper_d;
  logic              mirror_q, mirror_d;
  logic              battery_q, battery_d;
  logic              trainer_q, trainer_d;

  logic              active, wr_state, fifo_empty, fifo_full;
  logic              push, push_ok, pop, overflow, mem_we_w;
  logic [7:0]        head;
  logic [3:0]        idx;
  logic [ADDR_W:0]   prg_size, chr_size;
  logic              size_bad, last_prg, last_chr;

  function automatic logic [7:0] magic_byte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h4E;
      2'd1:    return 8'h45;
      2'd2:    return 8'h53;
      default: return 8'h1A;
    endcase
  endfunction

  assign active     = (state_q == S_HDR) || (state_q == S_TRAIN) ||
                      (state_q == S_PRG) || (state_q == S_CHR);
  assign wr_state   = (state_q == S_PRG) || (state_q == S_CHR);
  assign fifo_empty = (fill_q == '0);
  assign fifo_full  = (fill_q == (PTR_W+1)'(FIFO_DEPTH));
  assign head       = fifo_q[rd_ptr_q];
  assign idx        = cnt_q[3:0];

  // start masks the write request so an aborted load cannot complete a write
  assign mem_we_w = wr_state && !fifo_empty && !start;
  assign pop      = !start && ((((state_q == S_HDR) || (state_q == S_TRAIN)) && !fifo_empty) ||
                               (mem_we_w && mem_ready));
  assign push     = active && in_valid && !start;
  assign push_ok  = push && (!fifo_full || pop);
  assign overflow = push && fifo_full && !pop;

  // Sizes are one bit wider than the address so no comparison can wrap
  assign prg_size = (ADDR_W+1)'(prg_banks_q) << 14;
  assign chr_size = (ADDR_W+1)'(chr_banks_q) << 13;
  assign size_bad = (prg_banks_q == '0) || (prg_size > {1'b0, CHR_BASE}) ||
                    (chr_size > CHR_ROOM);
  assign last_prg = ({1'b0, cnt_q} == prg_size - (ADDR_W+1)'(1));
  assign last_chr = ({1'b0, cnt_q} == chr_size - (ADDR_W+1)'(1));

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    prg_banks_d = prg_banks_q;
    chr_banks_d = chr_banks_q;
    mapper_d    = mapper_q;
    mirror_d    = mirror_q;
    battery_d   = battery_q;
    trainer_d   = trainer_q;
    wr_ptr_d    = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    fill_d      = fill_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);

    case (state_q)
      S_HDR: if (pop) begin
        cnt_d = cnt_q + ADDR_W'(1);
        case (idx)
          4'd4: prg_banks_d = head;
          4'd5: chr_banks_d = head;
          4'd6: begin
            mirror_d      = head[0];
            battery_d     = head[1];
            trainer_d     = head[2];
            mapper_d[3:0] = head[7:4];
          end
          4'd7: mapper_d[7:4] = head[7:4];
          default: ;
        endcase
        if (idx < 4'd4 && head != magic_byte(idx[1:0])) begin
          state_d = S_ERR;
          err_d   = E_MAGIC;
        end else if (idx == 4'd15) begin
          cnt_d = '0;
          if (size_bad) begin
            state_d = S_ERR;
            err_d   = E_SIZE;
          end else begin
            state_d = trainer_q ? S_TRAIN : S_PRG;
          end
        end
      end
      S_TRAIN: if (pop) begin
        if (cnt_q == ADDR_W'(511)) begin
          cnt_d   = '0;
          state_d = S_PRG;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      S_PRG: if (pop) begin
        if (last_prg) begin
          cnt_d   = '0;
          state_d = (chr_banks_q == '0) ? S_DONE : S_CHR;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      S_CHR: if (pop) begin
        if (last_chr) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase

    if (overflow) begin
      state_d = S_ERR;
      err_d   = E_OVF;
    end

    if (state_d == S_ERR || state_d == S_DONE) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end

    if (start) begin
      state_d     = S_HDR;
      err_d       = E_NONE;
      cnt_d       = '0;
      prg_banks_d = '0;
      chr_banks_d = '0;
      mapper_d    = '0;
      mirror_d    = 1'b0;
      battery_d   = 1'b0;
      trainer_d   = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      fill_d      = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      err_q       <= E_NONE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      prg_banks_q <= '0;
      chr_banks_q <= '0;
      mapper_q    <= '0;
      mirror_q    <= 1'b0;
      battery_q   <= 1'b0;
      trainer_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      prg_banks_q <= prg_banks_d;
      chr_banks_q <= chr_banks_d;
      mapper_q    <= mapper_d;
      mirror_q    <= mirror_d;
      battery_q   <= battery_d;
      trainer_q   <= trainer_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_q <= '{default: '0};
    end else if (push_ok) begin
      fifo_q[wr_ptr_q] <= in_data;
    end
  end

  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    if (mem_we_w) begin
      mem_addr = (state_q == S_CHR) ? CHR_BASE + cnt_q : cnt_q;
      mem_din  = head;
    end
  end

  assign mem_we      = mem_we_w;
  assign loading     = active;
  assign done        = (state_q == S_DONE);
  assign error       = err_q;
  assign prg_banks   = prg_banks_q;
  assign chr_banks   = chr_banks_q;
  assign mapper      = mapper_q;
  assign mirroring   = mirror_q;
  assign has_battery = battery_q;

endmodule

// File: tb/tb_ines_rom_writer.sv
// Directed load scenarios with random payload bytes; every accepted write is
// matched against an expected (address, data) list derived from the image.
module tb_ines_rom_writer;

  localparam int unsigned ADDR_W   = 22;
  localparam logic [21:0] CHR_BASE = 22'h200000;

  typedef struct packed {
    logic [21:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk, reset, start, in_valid, mem_ready;
  logic [7:0]  in_data;
  logic [21:0] mem_addr;
  logic [7:0]  mem_din, prg_banks, chr_banks, mapper;
  logic        mem_we, loading, done, mirroring, has_battery;
  logic [1:0]  error;

  int checks = 0;
  int errors = 0;
  int ready_mode;
  int zeros = 0;
  int pace = 0;
  bit jitter = 0;
  wr_t exp_q[$];

  ines_rom_writer #(.ADDR_W(22), .CHR_BASE(22'h200000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_ready(mem_ready),
    .loading(loading), .done(done), .error(error), .prg_banks(prg_banks),
    .chr_banks(chr_banks), .mapper(mapper), .mirroring(mirroring),
    .has_battery(has_battery)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Mode 0: never ready, 1: always ready, 2: random but never low 3 cycles running
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: mem_ready = 1'b0;
      1: mem_ready = 1'b1;
      default: begin
        mem_ready = (zeros >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
        zeros = mem_ready ? 0 : zeros + 1;
      end
    endcase
  end

  always @(negedge clk) begin
    wr_t w;
    if (mem_we === 1'b1 && mem_ready === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed addr 'h%0h data 'h%0h, expected no write",
               mem_addr, mem_din);
      end
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(w.a));
        chk("wr_data", 32'(mem_din), 32'(w.d));
      end
    end
  end

  function automatic bit size_ok(input int p, input int c);
    return (p != 0) && (p * 16384 <= 'h200000) && (c * 8192 <= 'h400000 - 'h200000);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (pace) begin @(posedge clk); #1; end
    if (jitter && $urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
  endtask

  task automatic send_header(input logic [7:0] b4, b5, b6, b7);
    send_byte(8'h4E); send_byte(8'h45); send_byte(8'h53); send_byte(8'h1A);
    send_byte(b4); send_byte(b5); send_byte(b6); send_byte(b7);
    repeat (8) send_byte(8'h00);
  endtask

  task automatic send_body(input int n, input logic [21:0] base, input bit no_aa);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom);
      if (no_aa && d == 8'hAA) d = 8'h55;
      exp_q.push_back('{a: base + 22'(i), d: d});
      send_byte(d);
    end
  endtask

  task automatic pulse_start();
    exp_q.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] d0;
    logic [7:0] sp [3];
    logic [7:0] sc [3];
    sp = '{8'h81, 8'h00, 8'h80};
    sc = '{8'h01, 8'h00, 8'hFF};
    in_valid = 1'b0; in_data = '0; start = 1'b0; mem_ready = 1'b0; ready_mode = 1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_loading", 32'(loading), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_prg_banks", 32'(prg_banks), 0);
    send_byte(8'h4E);
    chk("idle_ignores_loading", 32'(loading), 0);
    chk("idle_ignores_error", 32'(error), 0);

    // Plain image: 2 PRG banks, 1 CHR bank
    pulse_start();
    chk("start_loading", 32'(loading), 1);
    send_header(8'h02, 8'h01, 8'h01, 8'h00);
    send_body(32768, 22'h0, 1'b0);
    send_body(8192, CHR_BASE, 1'b0);
    wait_done(200);
    chk("t1_done", 32'(done), 1);
    chk("t1_loading", 32'(loading), 0);
    chk("t1_error", 32'(error), 0);
    chk("t1_prg_banks", 32'(prg_banks), 2);
    chk("t1_chr_banks", 32'(chr_banks), 1);
    chk("t1_mirroring", 32'(mirroring), 1);
    chk("t1_battery", 32'(has_battery), 0);
    chk("t1_mapper", 32'(mapper), 0);
    chk("t1_writes_left", 32'(exp_q.size()), 0);
    chk("t1_mem_we", 32'(mem_we), 0);

    // Trainer present, mapper 0x21, CHR-RAM, jittered input timing
    jitter = 1;
    pulse_start();
    send_header(8'h01, 8'h00, 8'h14, 8'h20);
    repeat (512) send_byte(8'hAA);
    send_body(16384, 22'h0, 1'b1);
    wait_done(200);
    jitter = 0;
    chk("t2_done", 32'(done), 1);
    chk("t2_mapper", 32'(mapper), {24'h0, 4'h2, 4'h1});
    chk("t2_mirroring", 32'(mirroring), 0);
    chk("t2_battery", 32'(has_battery), 0);
    chk("t2_chr_banks", 32'(chr_banks), 0);
    chk("t2_writes_left", 32'(exp_q.size()), 0);

    // Bad magic in byte 3
    pulse_start();
    send_byte(8'h4E); send_byte(8'h45); send_byte(8'h53);
    chk("t3_pre_error", 32'(error), 0);
    chk("t3_pre_loading", 32'(loading), 1);
    send_byte(8'h1B);
    @(posedge clk); #1;
    chk("t3_error", 32'(error), 1);
    chk("t3_loading", 32'(loading), 0);
    repeat (12) send_byte(8'h00);
    chk("t3_error_sticky", 32'(error), 1);
    chk("t3_mem_we", 32'(mem_we), 0);
    chk("t3_done", 32'(done), 0);

    // FIFO overflow with memory stalled
    ready_mode = 0;
    pulse_start();
    chk("t4_error_cleared", 32'(error), 0);
    send_header(8'h01, 8'h00, 8'h00, 8'h00);
    d0 = 8'($urandom);
    send_byte(d0);
    repeat (3) send_byte(8'($urandom));
    chk("t4_we_held", 32'(mem_we), 1);
    chk("t4_addr_held", 32'(mem_addr), 0);
    chk("t4_din_held", 32'(mem_din), 32'(d0));
    chk("t4_no_error_yet", 32'(error), 0);
    send_byte(8'($urandom));
    chk("t4_error", 32'(error), 2);
    chk("t4_mem_we", 32'(mem_we), 0);
    chk("t4_loading", 32'(loading), 0);
    chk("t4_prg_hold", 32'(prg_banks), 1);

    // Size rule boundaries
    ready_mode = 1;
    for (int k = 0; k < 3; k++) begin
      pulse_start();
      send_header(sp[k], sc[k], 8'h00, 8'h00);
      repeat (2) begin @(posedge clk); #1; end
      chk("t5_error", 32'(error), size_ok(int'(sp[k]), int'(sc[k])) ? 0 : 3);
      chk("t5_loading", 32'(loading), 32'(size_ok(int'(sp[k]), int'(sc[k]))));
      chk("t5_prg_banks", 32'(prg_banks), 32'(sp[k]));
    end

    // Abort mid-PRG under random backpressure, then reload a fresh image
    ready_mode = 2;
    pace = 2;
    pulse_start();
    send_header(8'h02, 8'h00, 8'h00, 8'h00);
    send_body(300, 22'h0, 1'b0);
    pulse_start();
    chk("t6_meta_cleared", 32'(prg_banks), 0);
    chk("t6_we_after_start", 32'(mem_we), 0);
    chk("t6_loading", 32'(loading), 1);
    ready_mode = 1;
    pace = 0;
    send_header(8'h01, 8'h00, 8'h03, 8'h50);
    send_body(16384, 22'h0, 1'b0);
    wait_done(200);
    chk("t6_done", 32'(done), 1);
    chk("t6_prg_banks", 32'(prg_banks), 1);
    chk("t6_mapper", 32'(mapper), 32'h50);
    chk("t6_mirroring", 32'(mirroring), 1);
    chk("t6_battery", 32'(has_battery), 1);
    chk("t6_writes_left", 32'(exp_q.size()), 0);
    ready_mode = 0;
    repeat (6) send_byte(8'($urandom));
    chk("t6_trailing_error", 32'(error), 0);
    chk("t6_trailing_done", 32'(done), 1);
    chk("t6_trailing_we", 32'(mem_we), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ines_rom_writer.md
Name: ines_rom_writer

Overview:
- Consumer end of the SD loader's ROM byte stream (data byte + one-cycle valid pulse, no backpressure).
- Parses the 16-byte iNES header, discards the optional 512-byte trainer, and writes PRG and CHR data into external memory (SDRAM) through a valid/ready write port.
- Exposes cartridge metadata (bank counts, mapper, mirroring, battery) and done/error status to the NES core.

Parameters:
- ADDR_W, 22, memory byte-address width (4 MB space).
- CHR_BASE, 22'h200000, first CHR byte address; PRG region is [0, CHR_BASE), CHR region is [CHR_BASE, 2^ADDR_W).
- FIFO_DEPTH, 4, input buffer entries (power of 2, >=2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse: clear all state and begin a new load.
- in_data  in  8  streamed ROM byte.
- in_valid  in  1  one-cycle pulse: in_data is valid.
- mem_addr  out  ADDR_W  write byte address.
- mem_din  out  8  write data.
- mem_we  out  1  write request; held with addr/din stable until mem_ready.
- mem_ready  in  1  memory accepts write this cycle when mem_we=1.
- loading  out  1  load in progress.
- done  out  1  all PRG/CHR bytes accepted; sticky.
- error  out  2  0=none, 1=bad magic, 2=FIFO overflow, 3=size invalid; sticky.
- prg_banks  out  8  header byte 4 (16 KB units).
- chr_banks  out  8  header byte 5 (8 KB units; 0 = CHR-RAM).
- mapper  out  8  {byte7[7:4], byte6[7:4]}.
- mirroring  out  1  byte6[0].
- has_battery  out  1  byte6[1].

Behaviour:
- Reset (async) or start (sync): all outputs 0, state IDLE→HDR on start (reset leaves IDLE), FIFO emptied, byte counter 0. Metadata outputs are cleared on start and hold their values after done or error.
- FIFO: a push occurs when in_valid=1 and state is HDR/TRAIN/PRG/CHR; in_valid is ignored in IDLE/DONE/ERR. Overflow is a push while full with no pop in the same cycle; it goes to ERR with error=2 and drops the byte. A simultaneous push and pop on a full FIFO is legal.
- Pops: HDR and TRAIN pop one entry per cycle when the FIFO is non-empty. PRG and CHR present the FIFO head on mem_din/mem_addr with mem_we=1, and pop on mem_we&mem_ready.
- State HDR: counter 0..15 indexes header bytes.
  - Bytes 0-3 must equal 4E 45 53 1A; a mismatch at any byte goes to ERR with error=1 immediately.
  - Bytes 4, 5, 6, 7 latch prg_banks, chr_banks, mirroring/has_battery/trainer flag and mapper.
  - After byte 15: if prg_banks=0, or prg_banks*16384 > CHR_BASE, or chr_banks*8192 > 2^ADDR_W - CHR_BASE, go to ERR with error=3. Otherwise go to TRAIN if trainer=1, else PRG. The counter resets to 0.
- TRAIN: discard 512 bytes, then go to PRG.
- PRG: mem_addr = counter. After the write of byte prg_banks*16384-1 is accepted, go to CHR, or to DONE if chr_banks=0.
- CHR: mem_addr = CHR_BASE + counter. After the write of byte chr_banks*8192-1 is accepted, go to DONE.
- Arithmetic: the counter is ADDR_W bits. Size products are computed in ADDR_W+1 bits so no comparison wraps.
- DONE: done=1, loading=0, mem_we=0. Trailing stream bytes are ignored and do not raise overflow.
- ERR: loading=0, mem_we=0, FIFO flushed, in_valid ignored, until start.
- loading=1 exactly in HDR/TRAIN/PRG/CHR.
- start mid-load: abort with no further mem_we after that cycle and restart at HDR. A pending unaccepted write is dropped.
- Latency: the first PRG byte is presented on mem_we no earlier than 1 cycle after it is pushed.

Test Plan:
- Header 4E 45 53 1A 02 01 01 00 + 8×00, 32768 PRG bytes + 8192 CHR bytes, mem_ready=1 → prg_banks=2, chr_banks=1, mirroring=1, mapper=0. Last PRG write at addr 0x007FFF, first CHR write at 0x200000, last at 0x201FFF, done=1.
- Byte 6=0x14, byte 7=0x20 (trainer, mapper 0x21), 512 trainer bytes of 0xAA → mapper=0x21. No 0xAA is ever written; the first PRG byte lands at addr 0.
- Magic 4E 45 53 1B → error=1 after byte 3, loading=0, no mem_we ever.
- mem_ready held 0 while 5 bytes arrive (FIFO_DEPTH=4) → error=2 on the 5th push, mem_we drops.
- chr_banks=0, prg_banks=1 → done after write to 0x003FFF with no CHR writes. prg_banks=0x81 → error=3 after header.
- start pulsed midway through PRG, then a valid image with prg_banks=1 streamed → metadata refreshed, writes restart at addr 0, done=1.
